branch_resolve_queue: RTL
=========================

// Module: branch_resolve_queue
// PURPOSE
//  In-order queue of in-flight branch predictions between fetch (predict) and execute (resolve).
//  Fetch pushes each predicted branch; execute resolves branches oldest-first.
//  The block compares outcome vs prediction and drives the pattern-history update
//  (upd_detected/upd_taken -> Br_Detected/Br_Comp_Result). On mispredict it redirects fetch and flushes.
// PARAMETERS
//  XLEN   32  PC/target width
//  DEPTH  4   queue entries, power of two, >=2
//  AW     2   log2(DEPTH), pointer width
// PORTS
//  clk               in   1     clock, all state on posedge
//  rst_n             in   1     asynchronous, active-low reset
//  push_valid        in   1     fetch has a predicted branch
//  push_ready        out  1     queue accepts push this cycle
//  push_pc           in   XLEN  branch PC
//  push_pred_taken   in   1     predicted direction
//  push_pred_target  in   XLEN  predicted target (valid when pred_taken)
//  res_valid         in   1     execute resolves oldest branch this cycle
//  res_taken         in   1     actual direction
//  res_target        in   XLEN  actual target
//  upd_detected      out  1     predictor update strobe (registered)
//  upd_taken         out  1     actual outcome for predictor (registered)
//  redirect_valid    out  1     mispredict: refetch from redirect_pc (registered, 1 cycle)
//  redirect_pc       out  XLEN  corrected fetch PC
//  occupancy         out  AW+1  valid entries, 0..DEPTH
//  underflow_err     out  1     sticky: res_valid seen while empty
// BEHAVIOUR
//  Reset: all outputs 0; rd/wr ptrs 0; occupancy 0; push_ready 1 after reset release.
//  Storage: circular buffer {pc, pred_taken, pred_target}; ptrs AW+1 bits, wrap mod DEPTH.
//  push_ready = (occupancy != DEPTH) && !redirect_valid.
//  Push fires on push_valid && push_ready; entry written at wr_ptr, wr_ptr+1.
//  Resolve (res_valid && occupancy!=0): compare against head entry, rd_ptr+1.
//   mispredict = (pred_taken != res_taken) || (res_taken && pred_target != res_target).
//   Next cycle: upd_detected=1, upd_taken=res_taken, for exactly 1 cycle.
//   If mispredict, next cycle: redirect_valid=1 and redirect_pc = res_taken ? res_target : pc+4
//   (mod 2^XLEN); queue fully flushed at the same edge (wr_ptr := rd_ptr+1, occupancy 0).
//  Resolve from full + push in same cycle: push_ready is 0, no push; queue goes to DEPTH-1.
//  Resolve (no mispredict) + push, not full: both fire; occupancy unchanged.
//  Mispredict + push in same cycle: flush wins, pushed entry discarded.
//  res_valid while empty: no state change, no upd strobe; underflow_err set until reset.
//  redirect_pc holds last value when redirect_valid=0; upd_taken holds when upd_detected=0.
//  Reset mid-operation: immediate async clear of ptrs, occupancy and all outputs.
// STRUCTURE
//  bp_defs.vh: XLEN, INSN_BYTES (4), entry field offsets, shared with predictor and fetch.
//  Sub-module bp_fifo_mem: DEPTH x (2*XLEN+1) register array, 1 write port, async read of head.
//  Top: ptr/occupancy logic, compare, registered update/redirect outputs.
// TESTING
//  T1 reset: rst_n=0 mid-stream -> occupancy=0, upd_detected=0, redirect_valid=0, push_ready=1.
//  T2 correct: push pc=0x100 pred NT; resolve NT -> next cycle upd_detected=1, upd_taken=0, no redirect.
//  T3 dir mispredict: push pc=0x200 pred NT, then 2 more; resolve T tgt 0x400
//     -> redirect_valid=1, redirect_pc=0x400, occupancy=0, push_ready=0 that cycle.
//  T4 target mispredict: pred T tgt 0x80, actual T tgt 0x90 -> redirect_pc=0x90; pred T, actual NT
//     at pc 0xFFFFFFFC -> redirect_pc=0x0 (wrap).
//  T5 full: 4 pushes -> push_ready=0, occupancy=4; resolve+push same cycle -> occupancy 3, push dropped;
//     20 push/resolve pairs -> pointer wrap, FIFO order kept.
//  T6 underflow: res_valid when empty -> underflow_err=1 sticky, no upd strobe, ptrs unchanged.

Source files
------------

// File: rtl/branch_resolve_queue_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue_pkg
//   Shared definitions for the branch resolve queue: datapath width, queue
//   depth, instruction size and the layout of one queued prediction.
//   This is the single source of these constants for the predictor and fetch.
// -----------------------------------------------------------------------------
package branch_resolve_queue_pkg;

  localparam int BRQ_XLEN   = 32;                 // PC / target width
  localparam int BRQ_DEPTH  = 4;                  // entries, power of two, >= 2
  localparam int BRQ_AW     = $clog2(BRQ_DEPTH);  // index width
  localparam int INSN_BYTES = 4;                  // fall-through PC increment

  // One in-flight prediction, laid out as {pc, pred_taken, pred_target}.
  typedef struct packed {
    logic [BRQ_XLEN-1:0] pc;
    logic                pred_taken;
    logic [BRQ_XLEN-1:0] pred_target;
  } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue_if.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue_if
//   Bundles the fetch push handshake, the execute resolve bus and the
//   predictor/redirect/status outputs of the branch resolve queue.
//   modport slave  : the queue itself
//   modport master : the fetch/execute side that drives pushes and resolves
// -----------------------------------------------------------------------------
interface branch_resolve_queue_if;
  import branch_resolve_queue_pkg::*;

  // push (fetch -> queue)
  logic                push_valid;
  logic                push_ready;
  logic [BRQ_XLEN-1:0] push_pc;
  logic                push_pred_taken;
  logic [BRQ_XLEN-1:0] push_pred_target;
  // resolve (execute -> queue)
  logic                res_valid;
  logic                res_taken;
  logic [BRQ_XLEN-1:0] res_target;
  // predictor update / redirect / status (queue -> outside)
  logic                upd_detected;
  logic                upd_taken;
  logic                redirect_valid;
  logic [BRQ_XLEN-1:0] redirect_pc;
  logic [BRQ_AW:0]     occupancy;
  logic                underflow_err;

  modport slave (
    input  push_valid, push_pc, push_pred_taken, push_pred_target,
    input  res_valid, res_taken, res_target,
    output push_ready,
    output upd_detected, upd_taken, redirect_valid, redirect_pc,
    output occupancy, underflow_err
  );

  modport master (
    output push_valid, push_pc, push_pred_taken, push_pred_target,
    output res_valid, res_taken, res_target,
    input  push_ready,
    input  upd_detected, upd_taken, redirect_valid, redirect_pc,
    input  occupancy, underflow_err
  );

endinterface

// File: rtl/branch_resolve_queue_fifo_mem.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue_fifo_mem
//   DEPTH x entry register array with one synchronous write port and an
//   asynchronous read port used to present the head entry.
//   clk        : write clock
//   i_wr_en    : write strobe
//   i_wr_addr  : write index
//   i_wr_data  : entry to store
//   i_rd_addr  : head index
//   o_rd_data  : head entry (combinational)
// -----------------------------------------------------------------------------
module branch_resolve_queue_fifo_mem
  import branch_resolve_queue_pkg::*;
(
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [BRQ_AW-1:0] i_wr_addr,
  input  brq_entry_t        i_wr_data,
  input  logic [BRQ_AW-1:0] i_rd_addr,
  output brq_entry_t        o_rd_data
);

  brq_entry_t r_mem [BRQ_DEPTH];

  // NOTE: storage has no reset; an entry is only read after it was written,
  // because validity is tracked by the pointers in the top level.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue
//   In-order queue of in-flight branch predictions. Fetch pushes predicted
//   branches, execute resolves them oldest-first. Each resolve produces a
//   one-cycle predictor update strobe; a mispredict additionally produces a
//   one-cycle fetch redirect and flushes every younger entry.
//   clk   : clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : push / resolve / update / redirect / status signals (slave side)
// -----------------------------------------------------------------------------
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  branch_resolve_queue_if.slave  bus
);

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [BRQ_AW:0]     r_wr_ptr;
  logic [BRQ_AW:0]     r_rd_ptr;
  logic                r_upd_detected;
  logic                r_upd_taken;
  logic                r_redirect_valid;
  logic [BRQ_XLEN-1:0] r_redirect_pc;
  logic                r_underflow_err;

  logic [BRQ_AW:0]     w_occ;
  logic                w_full;
  logic                w_empty;
  logic                w_push_ready;
  logic                w_push_fire;
  logic                w_res_fire;
  logic                w_mispredict;
  logic [BRQ_XLEN-1:0] w_fix_pc;
  logic                w_wr_en;
  brq_entry_t          w_head;
  brq_entry_t          w_push_entry;

  assign w_occ        = r_wr_ptr - r_rd_ptr;
  assign w_full       = (w_occ == (BRQ_AW+1)'(BRQ_DEPTH));
  assign w_empty      = (w_occ == '0);
  // Hold off fetch during the redirect cycle: it is still on the wrong path.
  assign w_push_ready = !w_full && !r_redirect_valid;
  assign w_push_fire  = bus.push_valid && w_push_ready;
  assign w_res_fire   = bus.res_valid && !w_empty;

  assign w_push_entry = '{pc:          bus.push_pc,
                          pred_taken:  bus.push_pred_taken,
                          pred_target: bus.push_pred_target};

  // A push that coincides with a mispredict belongs to the flushed path.
  assign w_wr_en = w_push_fire && !(w_res_fire && w_mispredict);

  branch_resolve_queue_fifo_mem u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr[BRQ_AW-1:0]),
    .i_wr_data (w_push_entry),
    .i_rd_addr (r_rd_ptr[BRQ_AW-1:0]),
    .o_rd_data (w_head)
  );

  // Outcome vs. head prediction. A not-taken outcome ignores the target.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_mispredict = 1'b0;
    w_fix_pc     = w_head.pc + BRQ_XLEN'(INSN_BYTES);
    if (w_head.pred_taken != bus.res_taken) begin
      w_mispredict = 1'b1;
    end else if (bus.res_taken && (w_head.pred_target != bus.res_target)) begin
      w_mispredict = 1'b1;
    end
    if (bus.res_taken) w_fix_pc = bus.res_target;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_upd_detected   <= 1'b0;
      r_upd_taken      <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_underflow_err  <= 1'b0;
    end else begin
      r_upd_detected   <= w_res_fire;
      r_redirect_valid <= w_res_fire && w_mispredict;

      if (w_res_fire) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_upd_taken <= bus.res_taken;
      end

      if (w_res_fire && w_mispredict) begin
        // Flush: the queue becomes empty right behind the resolved entry.
        r_wr_ptr      <= r_rd_ptr + 1'b1;
        r_redirect_pc <= w_fix_pc;
      end else if (w_push_fire) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end

      if (bus.res_valid && w_empty) r_underflow_err <= 1'b1;
    end
  end

  assign bus.push_ready     = w_push_ready;
  assign bus.upd_detected   = r_upd_detected;
  assign bus.upd_taken      = r_upd_taken;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.occupancy      = w_occ;
  assign bus.underflow_err  = r_underflow_err;

endmodule
